// File: rtl/bus_mem_responder.sv
// Bus-attached 32-bit memory with byte/word access, in-order pipelined reads and saturating counters.
// Build option: define BUS_MEM_ADDR_ECHO_EN to return the read address instead of memory data (no array).
module bus_mem_responder #(
  parameter logic [31:0] BASEADDR      = 32'h0000_0000,
  parameter logic [31:0] HIGHADDR      = 32'h0000_03FF,
  parameter logic [31:0] BYTE_BOUNDARY = 32'h8000_0000,
  parameter int          DEPTH_LOG2    = 8,
  parameter int          READ_LATENCY  = 1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic [31:0] BUS_ADD,
  inout  wire  [31:0] BUS_DATA,
  input  logic        BUS_RD,
  input  logic        BUS_WR,
  output logic        BUS_BYTE_ACCESS,
  output logic [15:0] RD_COUNT,
  output logic [15:0] WR_COUNT,
  output logic        COLLISION
);

  logic [31:0]           offs;
  logic                  in_range;
  logic                  byte_acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_result;
  logic                  exit_vld;
  logic [31:0]           exit_dat;

  logic [31:0] rd_data_q;
  logic        rd_seen_q;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        coll_q;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("bus_mem_responder: READ_LATENCY must be within 1..4");
    end
  endgenerate

  // Single unsigned compare: addresses below BASEADDR wrap to a large offset and fall out of range.
  assign offs     = BUS_ADD - BASEADDR;
  assign in_range = (offs <= (HIGHADDR - BASEADDR));
  assign word_idx = offs[DEPTH_LOG2+1:2];
  assign lane     = offs[1:0];
  assign byte_acc = (BUS_ADD < BYTE_BOUNDARY);
  assign wr_acc   = in_range & BUS_WR;
  assign rd_acc   = in_range & BUS_RD & ~BUS_WR;

  assign BUS_BYTE_ACCESS = byte_acc;

`ifdef BUS_MEM_ADDR_ECHO_EN
  logic unused_echo;
  assign unused_echo = ^{BUS_DATA, word_idx, lane};
  assign rd_result   = BUS_ADD;
`else
  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] mem_word;

  // Contents are never cleared; reset only blocks writes while asserted.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
    end else if (wr_acc) begin
      if (byte_acc) mem_q[word_idx][{lane, 3'b000} +: 8] <= BUS_DATA[7:0];
      else          mem_q[word_idx] <= BUS_DATA;
    end
  end

  assign mem_word  = mem_q[word_idx];
  assign rd_result = byte_acc ? {24'h0, mem_word[{lane, 3'b000} +: 8]} : mem_word;
`endif

  // RD_DATA itself is the last stage, so READ_LATENCY-1 intermediate stages are needed.
  generate
    if (READ_LATENCY <= 1) begin : g_lat1
      assign exit_vld = rd_acc;
      assign exit_dat = rd_result;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] vld_q;
      logic [31:0]             dat_q [READ_LATENCY-1];

      always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
          vld_q <= '0;
          for (int i = 0; i < READ_LATENCY-1; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= rd_acc;
          dat_q[0] <= rd_result;
          for (int i = 1; i < READ_LATENCY-1; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign exit_vld = vld_q[READ_LATENCY-2];
      assign exit_dat = dat_q[READ_LATENCY-2];
    end
  endgenerate

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_acc && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_acc && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      rd_data_q <= '0;
      rd_seen_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      coll_q    <= 1'b0;
    end else begin
      if (exit_vld) begin
        rd_data_q <= exit_dat;
        rd_seen_q <= 1'b1;
      end
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (in_range && BUS_RD && BUS_WR) coll_q <= 1'b1;
    end
  end

  assign RD_COUNT  = rd_cnt_q;
  assign WR_COUNT  = wr_cnt_q;
  assign COLLISION = coll_q;
  assign BUS_DATA  = (rd_seen_q && !BUS_WR) ? rd_data_q : 32'hz;

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter BASEADDR, 32'h0000_0000, lowest decoded bus address.
REQ-002 Parameter HIGHADDR, 32'h0000_03FF, highest decoded bus address (inclusive).
REQ-003 Parameter BYTE_BOUNDARY, 32'h8000_0000; addresses below it are byte accesses, addresses at or above it are word accesses.
REQ-004 Parameter DEPTH_LOG2, 8, memory holds 2^DEPTH_LOG2 words of 32 bits.
REQ-005 Parameter READ_LATENCY, 1, BUS_CLK cycles from sampled BUS_RD to read-data update; legal range 1..4.
REQ-006 BUS_CLK  input  1  sole clock; all logic on its rising edge.
REQ-007 BUS_RST_N  input  1  asynchronous, active-low reset.
REQ-008 BUS_ADD  input  32  bus address.
REQ-009 BUS_DATA  inout  32  bus data; driven by this block only as defined in REQ-021, high-Z otherwise.
REQ-010 BUS_RD  input  1  read strobe, one cycle per access.
REQ-011 BUS_WR  input  1  write strobe, one cycle per access.
REQ-012 BUS_BYTE_ACCESS  output  1  combinational: 1 when BUS_ADD < BYTE_BOUNDARY, else 0.
REQ-013 RD_COUNT  output  16  saturating count of accepted reads.
REQ-014 WR_COUNT  output  16  saturating count of accepted writes.
REQ-015 COLLISION  output  1  sticky flag, set when BUS_RD and BUS_WR are sampled high in the same cycle on an in-range address.

Function
REQ-016 Access is in range when BASEADDR <= BUS_ADD <= HIGHADDR; out-of-range strobes are ignored: no memory change, no count change, no pipeline entry.
REQ-017 Word index = (BUS_ADD - BASEADDR)[DEPTH_LOG2+1:2]; byte lane = (BUS_ADD - BASEADDR)[1:0].
REQ-018 Byte write: only the selected lane is updated, from BUS_DATA[7:0]; word write: all 32 bits are updated, lane bits ignored; the memory is updated on the edge where BUS_WR is sampled.
REQ-019 A read samples the memory on the edge where BUS_RD is sampled and enters a READ_LATENCY-deep in-order pipeline; back-to-back reads every cycle are supported, each result arriving exactly READ_LATENCY cycles after its strobe.
REQ-020 Byte read result = selected lane in bits [7:0], bits [31:8] zero; word read result = full word; on pipeline exit the result is loaded into the RD_DATA register.
REQ-021 BUS_DATA is driven with RD_DATA when BUS_WR is low and at least one in-range read has completed since reset; it is high-Z when BUS_WR is high.
REQ-022 A write at edge N followed by a read of the same address at edge N+1 returns the new data.
REQ-023 Simultaneous BUS_RD and BUS_WR, in range: the write executes, the read is dropped, WR_COUNT increments, RD_COUNT does not, and COLLISION is set until reset.
REQ-024 RD_COUNT and WR_COUNT hold at 16'hFFFF and do not wrap.
REQ-025 Memory contents are not reset; reads before any write return undefined data.

Reset
REQ-026 Asserting BUS_RST_N low asynchronously clears the read pipeline (pending reads discarded), RD_DATA to 0, RD_COUNT to 0, WR_COUNT to 0 and COLLISION to 0, and puts BUS_DATA in high-Z until the next completed in-range read.
REQ-027 Strobes sampled while BUS_RST_N is low are ignored; normal operation resumes on the first rising edge after deassertion.

Configuration
REQ-028 Macro BUS_MEM_ADDR_ECHO_EN: when defined, every in-range read returns the sampled BUS_ADD instead of memory data, with the same latency and counting rules, writes update counters only and the memory array is not instantiated; when undefined, memory behaviour per REQ-016..REQ-025 applies.

Verification
REQ-029 Word write 32'hDEADBEEF to 32'h8000_0010 (BASEADDR 32'h8000_0000), then read it with READ_LATENCY=3 -> BUS_DATA = 32'hDEADBEEF exactly 3 cycles after BUS_RD, and BUS_BYTE_ACCESS = 0.
REQ-030 Byte writes 8'h11/22/33/44 to 32'h0000_0000..0003, then a byte read at 32'h0000_0002 -> 32'h0000_0033; BUS_BYTE_ACCESS = 1.
REQ-031 Four back-to-back reads of 4 distinct addresses -> 4 results returned in order on 4 consecutive cycles; RD_COUNT = 4.
REQ-032 BUS_RD and BUS_WR high together at an in-range address -> write takes effect, COLLISION = 1, RD_COUNT unchanged; write to HIGHADDR+4 -> no change anywhere.
REQ-033 Assert BUS_RST_N with 2 reads in flight -> no result is delivered, counters read 0, BUS_DATA is high-Z.
REQ-034 With BUS_MEM_ADDR_ECHO_EN defined, read of 32'h8000_0024 -> BUS_DATA = 32'h8000_0024 after READ_LATENCY cycles.
